// File: rtl/pwm_wr_if.sv
// Write port of pwm_gen: staged duty/period updates with an error pulse back.
interface pwm_wr_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
);
  logic             wr_valid;
  logic [SEL_W-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             wr_err;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_err);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_err);
endinterface

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator sharing one counter, with staged/shadow period and duty
// registers so that updates only take effect on a period boundary.
module pwm_gen #(
  parameter int unsigned         WIDTH        = 8,
  parameter int unsigned         CHANNELS     = 4,
  parameter logic [CHANNELS-1:0] POLARITY     = '0,
  parameter int unsigned         RESET_PERIOD = 19,
  parameter int unsigned         RESET_DUTY   = 2
) (
  input  logic                clk1ms,
  input  logic                reset,
  input  logic                enable,
  pwm_wr_if.slave             wr,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    counter,
  output logic                period_start,
  output logic [1:0]          state
);

  localparam int unsigned SelW = $clog2(CHANNELS + 1);
  localparam logic [SelW-1:0] SelPeriod = SelW'(CHANNELS);
  localparam logic [WIDTH-1:0] RstPeriod = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] RstDuty = WIDTH'(RESET_DUTY);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    counter_q, counter_d;
  logic [WIDTH-1:0]    staged_period_q, staged_period_d;
  logic [WIDTH-1:0]    shadow_period_q, shadow_period_d;
  logic [WIDTH-1:0]    staged_duty_q [CHANNELS];
  logic [WIDTH-1:0]    staged_duty_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_duty_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_duty_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic                wrap;
  logic                load;

  always_ff @(posedge clk1ms or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      counter_q       <= '0;
      staged_period_q <= RstPeriod;
      shadow_period_q <= RstPeriod;
      for (int i = 0; i < CHANNELS; i++) begin
        staged_duty_q[i] <= RstDuty;
        shadow_duty_q[i] <= RstDuty;
      end
      pwm_q   <= POLARITY;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      staged_period_q <= staged_period_d;
      shadow_period_q <= shadow_period_d;
      for (int i = 0; i < CHANNELS; i++) begin
        staged_duty_q[i] <= staged_duty_d[i];
        shadow_duty_q[i] <= shadow_duty_d[i];
      end
      pwm_q   <= pwm_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    staged_period_d = staged_period_q;
    shadow_period_d = shadow_period_q;
    staged_duty_d   = staged_duty_q;
    shadow_duty_d   = shadow_duty_q;
    state_d         = state_q;
    counter_d       = counter_q;
    pwm_d           = POLARITY;
    start_d         = 1'b0;

    wrap = (state_q != StIdle) && (counter_q == shadow_period_q);
    load = (state_q == StIdle) || wrap;

    // Shadows sample the pre-write staged values, so a write on the wrap cycle
    // only becomes visible one period later.
    if (load) begin
      shadow_period_d = staged_period_q;
      shadow_duty_d   = staged_duty_q;
    end

    if (wr.wr_valid) begin
      if (wr.wr_sel == SelPeriod) begin
        staged_period_d = wr.wr_data;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr.wr_sel == SelW'(i)) begin
          staged_duty_d[i] = wr.wr_data;
        end
      end
    end
    err_d = wr.wr_valid && (wr.wr_sel > SelPeriod);

    unique case (state_q)
      StIdle:  state_d = enable ? StRun : StIdle;
      StRun:   state_d = enable ? StRun : StDrain;
      StDrain: state_d = enable ? StRun : (wrap ? StIdle : StDrain);
      default: state_d = StIdle;
    endcase

    if (state_q == StIdle || state_d == StIdle || wrap) begin
      counter_d = '0;
    end else begin
      counter_d = counter_q + WIDTH'(1);
    end

    // Outputs are registered against the next counter value so they line up
    // with the counter cycle they describe.
    if (state_d != StIdle) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (counter_d < shadow_duty_d[i]) ^ POLARITY[i];
      end
      start_d = (counter_d == '0);
    end
  end

  assign pwm_out      = pwm_q;
  assign counter      = counter_q;
  assign period_start = start_q;
  assign state        = state_q;
  assign wr.wr_err    = err_q;

endmodule
